// File: rtl/ctrl_pkg.sv
// Shared encodings for the register-block control sequencer: opcodes, FSM states,
// datapath select codes and the EXEC/MEM strobe bundle.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LI   = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h6;
  localparam logic [3:0] OP_MVMS = 4'h7;
  localparam logic [3:0] OP_MVSM = 4'h8;
  localparam logic [3:0] OP_LIS  = 4'h9;
  localparam logic [3:0] OP_JAL  = 4'hA;
  localparam logic [3:0] OP_JR   = 4'hB;
  localparam logic [3:0] OP_BNZ  = 4'hC;
  localparam logic [3:0] OP_LRA  = 4'hD;
  localparam logic [3:0] OP_ILL  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  // mary source select
  localparam logic [1:0] SRC_MEM  = 2'b00;
  localparam logic [1:0] SRC_ALU  = 2'b01;
  localparam logic [1:0] SRC_SHEL = 2'b10;
  localparam logic [1:0] SRC_IMM  = 2'b11;

  // shelley source select; 2'b11 is never driven
  localparam logic [1:0] SSRC_MEM  = 2'b00;
  localparam logic [1:0] SSRC_IMM  = 2'b01;
  localparam logic [1:0] SSRC_MARY = 2'b10;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_IMM = 2'b01;
  localparam logic [1:0] PC_RA  = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  localparam logic RA_MEM = 1'b0;
  localparam logic RA_PC2 = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       mary_write;
    logic [1:0] mary_src;
    logic       shelley_write;
    logic [1:0] shelley_src;
    logic       comp_write;
    logic       ra_write;
    logic       ra_src;
  } ctrl_t;

endpackage

// File: rtl/reg_ctrl_fsm_if.sv
// Memory req/ack handshake between the control sequencer and the memory port.
interface reg_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_ack;

  modport master (output mem_req, output mem_we, input mem_ack);
  modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/reg_ctrl_decode.sv
// Opcode decoder: strobe/select bundles for the EXEC cycle and the MEM ack cycle,
// plus the classification flags the FSM uses to leave DECODE.
module reg_ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] op,
  input  logic       comp_zero,
  output ctrl_t      exec_ctrl,
  output ctrl_t      mem_ctrl,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    exec_ctrl  = '0;
    mem_ctrl   = '0;
    is_mem     = 1'b0;
    is_store   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_NOP: ;
      OP_LI: begin
        exec_ctrl.mary_write = 1'b1;
        exec_ctrl.mary_src   = SRC_IMM;
      end
      OP_ADD: begin
        exec_ctrl.alu_op     = ALU_ADD;
        exec_ctrl.mary_write = 1'b1;
        exec_ctrl.mary_src   = SRC_ALU;
      end
      OP_SUB: begin
        exec_ctrl.alu_op     = ALU_SUB;
        exec_ctrl.mary_write = 1'b1;
        exec_ctrl.mary_src   = SRC_ALU;
      end
      OP_CMP: begin
        exec_ctrl.alu_op     = ALU_SUB;
        exec_ctrl.comp_write = 1'b1;
      end
      OP_MVMS: begin
        exec_ctrl.shelley_write = 1'b1;
        exec_ctrl.shelley_src   = SSRC_MARY;
      end
      OP_MVSM: begin
        exec_ctrl.mary_write = 1'b1;
        exec_ctrl.mary_src   = SRC_SHEL;
      end
      OP_LIS: begin
        exec_ctrl.shelley_write = 1'b1;
        exec_ctrl.shelley_src   = SSRC_IMM;
      end
      OP_JAL: begin
        // link and jump land in the same cycle; ra captures pc+2 before pc moves
        exec_ctrl.ra_write = 1'b1;
        exec_ctrl.ra_src   = RA_PC2;
        exec_ctrl.pc_write = 1'b1;
        exec_ctrl.pc_src   = PC_IMM;
      end
      OP_JR: begin
        exec_ctrl.pc_write = 1'b1;
        exec_ctrl.pc_src   = PC_RA;
      end
      OP_BNZ: begin
        if (!comp_zero) begin
          exec_ctrl.pc_write = 1'b1;
          exec_ctrl.pc_src   = PC_IMM;
        end
      end
      OP_LW: begin
        is_mem              = 1'b1;
        mem_ctrl.mary_write = 1'b1;
        mem_ctrl.mary_src   = SRC_MEM;
      end
      OP_SW: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OP_LRA: begin
        is_mem            = 1'b1;
        mem_ctrl.ra_write = 1'b1;
        mem_ctrl.ra_src   = RA_MEM;
      end
      OP_HLT:  is_halt    = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_ctrl_fsm.sv
// Multicycle control sequencer: FETCH -> DECODE -> EXEC/MEM, with a wait-state
// watchdog on every memory access that traps a stalled handshake into FAULT.
module reg_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                clock,
  input  logic                reset,
  reg_ctrl_fsm_if.master      mem,
  input  logic [OPCODE_W-1:0] instr_op,
  input  logic                comp_zero,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_op,
  output logic                mary_write,
  output logic                shelley_write,
  output logic                comp_write,
  output logic                ra_write,
  output logic [1:0]          mary_src,
  output logic [1:0]          shelley_src,
  output logic                ra_src,
  output logic                halted,
  output logic                fault
);

  localparam int              CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic             expire;
  logic             req_c, we_c, ir_c;
  ctrl_t            ctl_c, ctl_o;
  ctrl_t            exec_ctrl, mem_ctrl;
  logic             is_mem, is_store, is_halt, is_illegal;

  reg_ctrl_decode u_dec (
    .op         (instr_op),
    .comp_zero  (comp_zero),
    .exec_ctrl  (exec_ctrl),
    .mem_ctrl   (mem_ctrl),
    .is_mem     (is_mem),
    .is_store   (is_store),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // an ack in the expiry cycle wins over the watchdog
  assign expire = (TIMEOUT != 0) && (wait_cnt == TO_MAX) && !mem.mem_ack;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    req_c     = 1'b0;
    we_c      = 1'b0;
    ir_c      = 1'b0;
    ctl_c     = '0;
    case (state)
      ST_FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ack) begin
          ir_c           = 1'b1;
          ctl_c.pc_write = 1'b1;
          ctl_c.pc_src   = PC_INC;
          state_nxt      = ST_DECODE;
        end else if (expire) begin
          state_nxt = ST_FAULT;
        end else begin
          cnt_nxt = (wait_cnt == TO_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        if (is_illegal)   state_nxt = ST_FAULT;
        else if (is_halt) state_nxt = ST_HALT;
        else if (is_mem)  state_nxt = ST_MEM;
        else              state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        ctl_c     = exec_ctrl;
        state_nxt = ST_FETCH;
      end
      ST_MEM: begin
        req_c = 1'b1;
        we_c  = is_store;
        if (mem.mem_ack) begin
          ctl_c     = mem_ctrl;
          state_nxt = ST_FETCH;
        end else if (expire) begin
          state_nxt = ST_FAULT;
        end else begin
          cnt_nxt = (wait_cnt == TO_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
        end
      end
      ST_HALT, ST_FAULT: ;
      default: state_nxt = ST_FAULT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
    end
  end

  // outputs are Mealy on mem_ack; reset forces everything quiet, including FETCH's req
  assign ctl_o       = reset ? '0 : ctl_c;
  assign mem.mem_req = req_c & ~reset;
  assign mem.mem_we  = we_c & ~reset;
  assign ir_write    = ir_c & ~reset;

  assign pc_write      = ctl_o.pc_write;
  assign pc_src        = ctl_o.pc_src;
  assign alu_op        = ctl_o.alu_op;
  assign mary_write    = ctl_o.mary_write;
  assign mary_src      = ctl_o.mary_src;
  assign shelley_write = ctl_o.shelley_write;
  assign shelley_src   = ctl_o.shelley_src;
  assign comp_write    = ctl_o.comp_write;
  assign ra_write      = ctl_o.ra_write;
  assign ra_src        = ctl_o.ra_src;

  assign halted = ~reset & ((state == ST_HALT) | (state == ST_FAULT));
  assign fault  = ~reset & (state == ST_FAULT);

endmodule
